// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one word per line.
// Latency: hit 1 cycle; miss 1 cycle + memory latency (response the cycle after iMC_En).
// Backpressure: en=0 freezes every register; one outstanding miss, new requests ignored while waiting.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   en                 global ready; all state holds when low
//   iIF_En / iIF_Pc    fetch request pulse and its PC
//   oIF_En / oIF_Ins   response pulse and instruction word
//   oMC_En / oMC_Addr  word read request to the memory controller
//   iMC_En / iMC_Dat   memory read response
module icache #(
  parameter int REG_DAT_W = 32,
  parameter int INS_DAT_W = 32,
  parameter int IDX_W     = 8,
  parameter int TAG_W     = REG_DAT_W - IDX_W - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iIF_En,
  input  logic [REG_DAT_W-1:0] iIF_Pc,
  output logic                 oIF_En,
  output logic [INS_DAT_W-1:0] oIF_Ins,
  output logic                 oMC_En,
  output logic [REG_DAT_W-1:0] oMC_Addr,
  input  logic                 iMC_En,
  input  logic [INS_DAT_W-1:0] iMC_Dat
);

  localparam int N_LINES = 1 << IDX_W;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t               state_q;
  logic [N_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q  [N_LINES];
  logic [INS_DAT_W-1:0] data_q [N_LINES];
  logic [IDX_W-1:0]     idx_q;
  logic [TAG_W-1:0]     ptag_q;
  logic                 if_en_q;
  logic [INS_DAT_W-1:0] if_ins_q;
  logic                 mc_en_q;
  logic [REG_DAT_W-1:0] mc_addr_q;

  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             hit;
  logic             fill_we;
  logic             unused_pc_lsbs;

  // Byte offset within the word plays no part in lookup.
  assign unused_pc_lsbs = ^iIF_Pc[1:0];
  assign pc_idx = iIF_Pc[IDX_W+1:2];
  assign pc_tag = iIF_Pc[REG_DAT_W-1:IDX_W+2];
  assign hit    = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  // The fill write must not happen on a reset cycle: a reset mid-miss aborts the fill.
  assign fill_we = en && !rst && (state_q == ST_WAIT) && iMC_En;

  // Tag and data arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[idx_q] <= iMC_Dat;
      tag_q[idx_q]  <= ptag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= '0;
      if_en_q   <= 1'b0;
      if_ins_q  <= '0;
      mc_en_q   <= 1'b0;
      mc_addr_q <= '0;
    end else if (en) begin
      if_en_q <= 1'b0;
      mc_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iIF_En) begin
            idx_q  <= pc_idx;
            ptag_q <= pc_tag;
            if (hit) begin
              if_ins_q <= data_q[pc_idx];
              if_en_q  <= 1'b1;
            end else begin
              mc_en_q   <= 1'b1;
              mc_addr_q <= {iIF_Pc[REG_DAT_W-1:2], 2'b00};
              state_q   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Any fetch request arriving here is dropped; only the fill matters.
          if (iMC_En) begin
            valid_q[idx_q] <= 1'b1;
            if_ins_q       <= iMC_Dat;
            if_en_q        <= 1'b1;
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oIF_En   = if_en_q;
  assign oIF_Ins  = if_ins_q;
  assign oMC_En   = mc_en_q;
  assign oMC_Addr = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// compared against an array-based model of a 256-line direct-mapped cache.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst, en, iIF_En, iMC_En;
  logic [31:0] iIF_Pc, iMC_Dat;
  logic        oIF_En, oMC_En;
  logic [31:0] oIF_Ins, oMC_Addr;

  int total = 0;
  int bad   = 0;

  // Reference model: line = (pc/4) mod 256, tag = pc / 1024.
  bit          m_valid [256];
  logic [21:0] m_tag   [256];
  logic [31:0] m_data  [256];

  always #5 clk = ~clk;

  icache dut (
    .clk(clk), .rst(rst), .en(en),
    .iIF_En(iIF_En), .iIF_Pc(iIF_Pc),
    .oIF_En(oIF_En), .oIF_Ins(oIF_Ins),
    .oMC_En(oMC_En), .oMC_Addr(oMC_Addr),
    .iMC_En(iMC_En), .iMC_Dat(iMC_Dat)
  );

  function automatic int m_line(input logic [31:0] pc);
    return int'((pc / 4) % 256);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_line(pc)] && (m_tag[m_line(pc)] == 22'(pc / 1024));
  endfunction

  function automatic void m_fill(input logic [31:0] pc, input logic [31:0] d);
    m_valid[m_line(pc)] = 1'b1;
    m_tag[m_line(pc)]   = 22'(pc / 1024);
    m_data[m_line(pc)]  = d;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endfunction

  // Drives one request; on a miss the memory answers mlat cycles after oMC_En is seen.
  task automatic fetch(input logic [31:0] pc, input int mlat, input logic [31:0] mdat,
                       output bit saw_hit, output bit saw_miss, output logic [31:0] maddr,
                       output bit resp, output logic [31:0] ins);
    @(negedge clk);
    iIF_En = 1'b1; iIF_Pc = pc;
    @(negedge clk);
    iIF_En = 1'b0;
    saw_hit = oIF_En; saw_miss = oMC_En; maddr = oMC_Addr;
    resp = oIF_En; ins = oIF_Ins;
    if (saw_miss) begin
      repeat (mlat - 1) @(negedge clk);
      iMC_En = 1'b1; iMC_Dat = mdat;
      @(negedge clk);
      iMC_En = 1'b0;
      resp = oIF_En; ins = oIF_Ins;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (oIF_En !== 1'b0) begin bad++; $display("FAIL reset_oIF_En got %b want 0", oIF_En); end
    total++; if (oIF_Ins !== 32'h0) begin bad++; $display("FAIL reset_oIF_Ins got %h want 0", oIF_Ins); end
    total++; if (oMC_En !== 1'b0) begin bad++; $display("FAIL reset_oMC_En got %b want 0", oMC_En); end
    total++; if (oMC_Addr !== 32'h0) begin bad++; $display("FAIL reset_oMC_Addr got %h want 0", oMC_Addr); end
    rst = 1'b0;
    m_clear();
  endtask

  task automatic test_cold_miss();
    bit h, m, r; logic [31:0] a, d;
    fetch(32'h4, 3, 32'h0010_0093, h, m, a, r, d);
    total++; if (m !== 1'b1 || h !== 1'b0) begin bad++; $display("FAIL cold_miss_req got mc=%b if=%b want mc=1 if=0", m, h); end
    total++; if (a !== 32'h4) begin bad++; $display("FAIL cold_miss_addr got %h want 00000004", a); end
    total++; if (r !== 1'b1 || d !== 32'h0010_0093) begin bad++; $display("FAIL cold_miss_resp got en=%b ins=%h want en=1 ins=00100093", r, d); end
    m_fill(32'h4, 32'h0010_0093);
  endtask

  task automatic test_hit_after_fill();
    bit h, m, r; logic [31:0] a, d;
    fetch(32'h4, 1, 32'hBAD0_0000, h, m, a, r, d);
    total++; if (h !== 1'b1 || m !== 1'b0) begin bad++; $display("FAIL hit_latency got if=%b mc=%b want if=1 mc=0", h, m); end
    total++; if (d !== 32'h0010_0093) begin bad++; $display("FAIL hit_data got %h want 00100093", d); end
  endtask

  task automatic test_eviction();
    bit h, m, r; logic [31:0] a, d;
    fetch(32'h404, 2, 32'hDEAD_BEEF, h, m, a, r, d);
    total++; if (m !== 1'b1 || a !== 32'h404) begin bad++; $display("FAIL evict_miss got mc=%b addr=%h want mc=1 addr=00000404", m, a); end
    total++; if (r !== 1'b1 || d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL evict_fill got en=%b ins=%h want en=1 ins=deadbeef", r, d); end
    m_fill(32'h404, 32'hDEAD_BEEF);
    fetch(32'h4, 2, 32'h0010_0093, h, m, a, r, d);
    total++; if (m !== 1'b1 || h !== 1'b0 || a !== 32'h4) begin bad++; $display("FAIL evict_rerequest got mc=%b if=%b addr=%h want mc=1 if=0 addr=00000004", m, h, a); end
    total++; if (d !== 32'h0010_0093) begin bad++; $display("FAIL evict_refill got %h want 00100093", d); end
    m_fill(32'h4, 32'h0010_0093);
  endtask

  task automatic test_unaligned();
    bit h, m, r; logic [31:0] a, d;
    fetch(32'h7, 1, 32'h0, h, m, a, r, d);
    total++; if (h !== 1'b1 || m !== 1'b0 || d !== 32'h0010_0093) begin bad++; $display("FAIL unaligned_hit got if=%b mc=%b ins=%h want if=1 mc=0 ins=00100093", h, m, d); end
    fetch(32'h10B, 1, 32'h1234_5678, h, m, a, r, d);
    total++; if (m !== 1'b1 || a !== 32'h108) begin bad++; $display("FAIL unaligned_miss_addr got mc=%b addr=%h want mc=1 addr=00000108", m, a); end
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL unaligned_miss_data got %h want 12345678", d); end
    m_fill(32'h108, 32'h1234_5678);
  endtask

  task automatic test_stall();
    bit h, m, r; logic [31:0] a, d;
    @(negedge clk); iIF_En = 1'b1; iIF_Pc = 32'h20;
    @(negedge clk); iIF_En = 1'b0;
    total++; if (oMC_En !== 1'b1) begin bad++; $display("FAIL stall_miss got mc=%b want 1", oMC_En); end
    en = 1'b0; iMC_En = 1'b1; iMC_Dat = 32'h5555_AAAA;
    @(negedge clk); iMC_En = 1'b0;
    @(negedge clk);
    total++; if (oMC_En !== 1'b1 || oIF_En !== 1'b0) begin bad++; $display("FAIL stall_hold got mc=%b if=%b want mc=1 if=0", oMC_En, oIF_En); end
    en = 1'b1;
    @(negedge clk);
    total++; if (oMC_En !== 1'b0 || oIF_En !== 1'b0) begin bad++; $display("FAIL stall_still_wait got mc=%b if=%b want mc=0 if=0", oMC_En, oIF_En); end
    iMC_En = 1'b1; iMC_Dat = 32'hCAFE_F00D;
    @(negedge clk); iMC_En = 1'b0;
    total++; if (oIF_En !== 1'b1 || oIF_Ins !== 32'hCAFE_F00D) begin bad++; $display("FAIL stall_fill got en=%b ins=%h want en=1 ins=cafef00d", oIF_En, oIF_Ins); end
    m_fill(32'h20, 32'hCAFE_F00D);
    fetch(32'h20, 1, 32'h0, h, m, a, r, d);
    total++; if (h !== 1'b1 || d !== 32'hCAFE_F00D) begin bad++; $display("FAIL stall_rehit got if=%b ins=%h want if=1 ins=cafef00d", h, d); end
  endtask

  task automatic test_reset_mid_miss();
    bit h, m, r; logic [31:0] a, d;
    @(negedge clk); iIF_En = 1'b1; iIF_Pc = 32'h30;
    @(negedge clk); iIF_En = 1'b0;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_clear();
    iMC_En = 1'b1; iMC_Dat = 32'h7777_7777;
    @(negedge clk); iMC_En = 1'b0;
    total++; if (oIF_En !== 1'b0) begin bad++; $display("FAIL rst_mid_stale got if=%b want 0", oIF_En); end
    fetch(32'h4, 2, 32'h0010_0093, h, m, a, r, d);
    total++; if (m !== 1'b1 || h !== 1'b0) begin bad++; $display("FAIL rst_mid_cold got mc=%b if=%b want mc=1 if=0", m, h); end
    m_fill(32'h4, 32'h0010_0093);
    // A request coincident with reset must be dropped.
    @(negedge clk); rst = 1'b1; iIF_En = 1'b1; iIF_Pc = 32'h4;
    @(negedge clk); rst = 1'b0; iIF_En = 1'b0;
    m_clear();
    @(negedge clk);
    total++; if (oIF_En !== 1'b0 || oMC_En !== 1'b0) begin bad++; $display("FAIL rst_drop_req got if=%b mc=%b want 0 0", oIF_En, oMC_En); end
  endtask

  task automatic test_back_to_back();
    bit h, m, r; logic [31:0] a, d;
    fetch(32'h4, 1, 32'h0010_0093, h, m, a, r, d); m_fill(32'h4, 32'h0010_0093);
    fetch(32'h8, 1, 32'h0020_0113, h, m, a, r, d); m_fill(32'h8, 32'h0020_0113);
    @(negedge clk); iIF_En = 1'b1; iIF_Pc = 32'h4;
    @(negedge clk); iIF_En = 1'b0;
    total++; if (oIF_En !== 1'b1 || oIF_Ins !== 32'h0010_0093) begin bad++; $display("FAIL b2b_first got en=%b ins=%h want en=1 ins=00100093", oIF_En, oIF_Ins); end
    @(negedge clk); iIF_En = 1'b1; iIF_Pc = 32'h8;
    total++; if (oIF_En !== 1'b0) begin bad++; $display("FAIL b2b_gap got en=%b want 0", oIF_En); end
    @(negedge clk); iIF_Pc = 32'h4;
    total++; if (oIF_En !== 1'b1 || oIF_Ins !== 32'h0020_0113) begin bad++; $display("FAIL b2b_second got en=%b ins=%h want en=1 ins=00200113", oIF_En, oIF_Ins); end
    @(negedge clk); iIF_En = 1'b0;
    total++; if (oIF_En !== 1'b1 || oIF_Ins !== 32'h0010_0093 || oMC_En !== 1'b0) begin bad++; $display("FAIL b2b_consecutive got en=%b ins=%h mc=%b want en=1 ins=00100093 mc=0", oIF_En, oIF_Ins, oMC_En); end
  endtask

  task automatic test_random();
    bit h, m, r, pred; logic [31:0] a, d, pc, md, exp_d;
    for (int i = 0; i < 80; i++) begin
      pc = ($urandom_range(0, 3) * 1024) + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3);
      md = $urandom;
      pred = m_hit(pc);
      exp_d = pred ? m_data[m_line(pc)] : md;
      fetch(pc, int'($urandom_range(1, 4)), md, h, m, a, r, d);
      total++; if (h !== pred || m !== !pred) begin bad++; $display("FAIL rand_kind pc=%h got if=%b mc=%b want hit=%b", pc, h, m, pred); end
      if (!pred) begin
        total++; if (a !== {pc[31:2], 2'b00}) begin bad++; $display("FAIL rand_addr pc=%h got %h want %h", pc, a, {pc[31:2], 2'b00}); end
        m_fill(pc, md);
      end
      total++; if (r !== 1'b1 || d !== exp_d) begin bad++; $display("FAIL rand_data pc=%h got en=%b ins=%h want en=1 ins=%h", pc, r, d, exp_d); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; iIF_En = 1'b0; iIF_Pc = '0; iMC_En = 1'b0; iMC_Dat = '0;
    test_reset();
    test_cold_miss();
    test_hit_after_fill();
    test_eviction();
    test_unaligned();
    test_stall();
    test_reset_mid_miss();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
